// File: rtl/pipelined_add_chain_pkg.sv
// +----------------------------------------------------------------------+
// | pipelined_add_pkg: defaults and per-stage add (wrap or saturate)     |
// | Optional: PIPELINED_ADD_CHAIN_SAT_EN selects saturating arithmetic.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package pipelined_add_pkg;

  localparam int unsigned PAC_WIDTH_DEF  = 16;
  localparam int unsigned PAC_STAGES_DEF = 2;
  localparam int unsigned PAC_INC_DEF    = 1;
  localparam int unsigned PAC_MAXW       = 64;

  // Operands arrive zero-extended to PAC_MAXW; the caller truncates to width.
  function automatic logic [PAC_MAXW-1:0] stage_add(
    input logic [PAC_MAXW-1:0] a,
    input logic [PAC_MAXW-1:0] inc,
    input int unsigned         width
  );
`ifdef PIPELINED_ADD_CHAIN_SAT_EN
    logic [PAC_MAXW:0] sum;
    logic [PAC_MAXW:0] lim;
    sum = {1'b0, a} + {1'b0, inc};
    lim = {{PAC_MAXW{1'b0}}, 1'b1} << width;
    if (sum >= lim) begin
      sum = lim - {{PAC_MAXW{1'b0}}, 1'b1};
    end
    stage_add = sum[PAC_MAXW-1:0];
`else
    logic [PAC_MAXW-1:0] mask;
    mask = (width >= PAC_MAXW) ? {PAC_MAXW{1'b1}}
                               : (({{(PAC_MAXW-1){1'b0}}, 1'b1} << width) - {{(PAC_MAXW-1){1'b0}}, 1'b1});
    stage_add = (a + inc) & mask;
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipelined_add_chain_stage.sv
// +----------------------------------------------------------------------+
// | pipelined_add_stage: one valid/data register pair of the add chain   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

import pipelined_add_pkg::*;

module pipelined_add_stage #(
  parameter int unsigned WIDTH = PAC_WIDTH_DEF,
  parameter int unsigned INC   = PAC_INC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv_i,
  input  logic             prev_v_i,
  input  logic [WIDTH-1:0] prev_d_i,
  output logic             v_o,
  output logic [WIDTH-1:0] d_o
);

  logic             v_q;
  logic             v_d;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] d_d;

  // Data only loads with a valid datum, so bubbles leave the last value in place.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (adv_i) begin
      v_d = prev_v_i;
      if (prev_v_i) begin
        d_d = WIDTH'(stage_add(PAC_MAXW'(prev_d_i), PAC_MAXW'(INC), WIDTH));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign v_o = v_q;
  assign d_o = d_q;

endmodule

`default_nettype wire

// File: rtl/pipelined_add_chain.sv
// +----------------------------------------------------------------------+
// | pipelined_add_chain: STAGES-deep valid/ready add-INC pipeline with   |
// | bubble collapsing and occupancy. Optional: PIPELINED_ADD_CHAIN_SAT_EN|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

import pipelined_add_pkg::*;

module pipelined_add_chain #(
  parameter int unsigned WIDTH  = PAC_WIDTH_DEF,
  parameter int unsigned STAGES = PAC_STAGES_DEF,
  parameter int unsigned INC    = PAC_INC_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             result,
  output logic [$clog2(STAGES+1)-1:0]  occupancy
);

  localparam int unsigned OCC_W = $clog2(STAGES + 1);

  logic [STAGES:0]   w_adv;
  logic [STAGES-1:0] w_v;
  logic [WIDTH-1:0]  w_d      [STAGES];
  logic [STAGES-1:0] w_prev_v;
  logic [WIDTH-1:0]  w_prev_d [STAGES];

  // A stage may advance if it is empty or the stage ahead of it advances.
  always_comb begin
    w_adv         = '0;
    w_adv[STAGES] = out_ready;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      w_adv[i] = !w_v[i] || w_adv[i+1];
    end
  end

  assign w_prev_v[0] = in_valid;
  assign w_prev_d[0] = in_data;

  for (genvar i = 0; i < int'(STAGES); i++) begin : g_stage
    if (i > 0) begin : g_link
      assign w_prev_v[i] = w_v[i-1];
      assign w_prev_d[i] = w_d[i-1];
    end

    pipelined_add_stage #(
      .WIDTH (WIDTH),
      .INC   (INC)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .adv_i    (w_adv[i]),
      .prev_v_i (w_prev_v[i]),
      .prev_d_i (w_prev_d[i]),
      .v_o      (w_v[i]),
      .d_o      (w_d[i])
    );
  end

  logic             w_accept;
  logic             w_drain;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  assign w_accept = in_valid && w_adv[0];
  assign w_drain  = w_v[STAGES-1] && out_ready;

  always_comb begin
    occ_d = occ_q;
    if (w_accept && !w_drain) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (w_drain && !w_accept) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign in_ready  = w_adv[0];
  assign out_valid = w_v[STAGES-1];
  assign result    = w_d[STAGES-1];
  assign occupancy = occ_q;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_add_chain.sv
// +----------------------------------------------------------------------+
// | tb_pipelined_add_chain: randomized bench with an item-level model    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_pipelined_add_chain;

  localparam int W     = 8;
  localparam int S     = 3;
  localparam int INC   = 100;
  localparam int OCC_W = $clog2(S + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     result;
  logic [OCC_W-1:0] occupancy;

  always #5 clk = ~clk;

  pipelined_add_chain #(
    .WIDTH  (W),
    .STAGES (S),
    .INC    (INC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .occupancy (occupancy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: each accepted datum gains S*INC overall, wrapped or clamped.
  function automatic logic [W-1:0] ref_out(input logic [W-1:0] x);
    longint unsigned t;
    longint unsigned maxv;
    t    = longint'(x) + longint'(S) * longint'(INC);
    maxv = (64'd1 << W) - 1;
`ifdef PIPELINED_ADD_CHAIN_SAT_EN
    if (t > maxv) t = maxv;
`else
    t = t & maxv;
`endif
    return t[W-1:0];
  endfunction

  // Items in flight, oldest first: stage position and final expected value.
  int           m_pos[$];
  logic [W-1:0] m_val[$];
  logic [W-1:0] m_res;

  task automatic step(input logic v, input logic r, input logic do_rst, input logic [W-1:0] data);
    logic m_valid, m_ready, acc, mv, moved_prev;
    int   p, prev_old;
    @(negedge clk);
    rst       = do_rst;
    in_valid  = v;
    out_ready = r;
    in_data   = data;
    #1;
    m_valid = (m_pos.size() > 0) && (m_pos[0] == S - 1);
    m_ready = (m_pos.size() < S) || r;
    check_eq("out_valid", 64'(out_valid), 64'(m_valid));
    check_eq("result",    64'(result),    64'(m_res));
    check_eq("occupancy", 64'(occupancy), 64'(m_pos.size()));
    check_eq("in_ready",  64'(in_ready),  64'(m_ready));

    if (do_rst) begin
      m_pos.delete();
      m_val.delete();
      m_res = '0;
    end else begin
      acc        = v && m_ready;
      moved_prev = 1'b0;
      prev_old   = -1;
      for (int k = 0; k < m_pos.size(); k++) begin
        p = m_pos[k];
        if (k == 0) mv = (p == S - 1) ? r : 1'b1;
        else        mv = (prev_old != p + 1) || moved_prev;
        prev_old   = p;
        moved_prev = mv;
        if (mv) m_pos[k] = p + 1;
      end
      if (m_pos.size() > 0 && m_pos[0] == S) begin
        void'(m_pos.pop_front());
        void'(m_val.pop_front());
      end
      if (acc) begin
        m_pos.push_back(0);
        m_val.push_back(ref_out(data));
      end
      if (m_pos.size() > 0 && m_pos[0] == S - 1) m_res = m_val[0];
    end
  endtask

  task automatic run_phase(input int pv, input int pr, input int n, input int prst);
    for (int c = 0; c < n; c++) begin
      step($urandom_range(0, 99) < pv, $urandom_range(0, 99) < pr,
           $urandom_range(0, 999) < prst, W'($urandom()));
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    m_res     = '0;
    repeat (2) @(posedge clk);

    // Directed: single datum 100 through the chain (wraps or clamps).
    step(1'b1, 1'b1, 1'b0, 8'd100);
    repeat (4) step(1'b0, 1'b1, 1'b0, 8'd18);
    // Fill with the consumer stalled, then drain.
    step(1'b1, 1'b0, 1'b0, 8'd1);
    step(1'b1, 1'b0, 1'b0, 8'd2);
    step(1'b1, 1'b0, 1'b0, 8'd3);
    repeat (3) step(1'b1, 1'b0, 1'b0, 8'd4);
    repeat (6) step(1'b0, 1'b1, 1'b0, 8'd0);
    // Bubbles then stall: items must pack towards the output.
    step(1'b1, 1'b1, 1'b0, 8'd100);
    repeat (2) step(1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b0, 1'b0, 8'd200);
    repeat (3) step(1'b0, 1'b0, 1'b0, 8'd0);
    repeat (5) step(1'b0, 1'b1, 1'b0, 8'd0);
    // Mid-operation reset, then a fresh datum.
    step(1'b1, 1'b1, 1'b0, 8'd5);
    step(1'b1, 1'b1, 1'b0, 8'd6);
    step(1'b0, 1'b1, 1'b1, 8'd0);
    step(1'b1, 1'b1, 1'b0, 8'd7);
    repeat (4) step(1'b0, 1'b1, 1'b0, 8'd0);

    run_phase(100, 100, 200, 0);
    run_phase(100,   0,  20, 0);
    run_phase( 50,  50, 400, 5);
    run_phase( 90,  20, 400, 5);
    run_phase( 20,  90, 300, 5);
    run_phase( 70,  70, 400, 10);
    run_phase(  0, 100,  10, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
